// File: rtl/ap_ctrl_pkg.sv
// Shared types for the HLS block-level control initiator: FSM states,
// the per-invocation latency record and pending-FIFO sizing helpers.
package ap_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_e;

   localparam int unsigned CNT_W_DEF      = 32;
   localparam int unsigned PEND_DEPTH_DEF = 4;
   localparam int unsigned PEND_PTR_W     = $clog2(PEND_DEPTH_DEF);

   typedef struct packed {
      logic [CNT_W_DEF-1:0] index;
      logic [CNT_W_DEF-1:0] latency;
   } rec_t;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ap_ctrl_ts_fifo.sv
// Show-ahead FIFO of start timestamps for invocations that are started but
// not yet done; push and pop may happen in the same cycle.
module ap_ctrl_ts_fifo
   import ap_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = PEND_DEPTH_DEF,
   parameter int unsigned W     = CNT_W_DEF,
   localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [W-1:0]     din_i,
   output logic [W-1:0]     dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PTR_W:0]   count_o
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is only legal when the head leaves the same cycle.
   assign push_ok = push_i & (~full_o | pop_i);
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/ap_ctrl_driver.sv
// Initiator for the ap_start/ap_ready/ap_done/ap_continue handshake: issues a
// commanded number of (possibly overlapping) invocations and reports latencies.
module ap_ctrl_driver
   import ap_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned PEND_DEPTH = PEND_DEPTH_DEF,
   parameter int unsigned WDOG_CYC   = 1000000
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             run_start,
   input  logic [CNT_W-1:0] run_count,
   output logic             busy,
   output logic             run_done,
   output logic             err_timeout,
   output logic             err_protocol,
   output logic             k_ap_start,
   input  logic             k_ap_ready,
   input  logic             k_ap_done,
   input  logic             k_ap_idle,
   output logic             k_ap_continue,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [CNT_W-1:0] rec_index,
   output logic [CNT_W-1:0] rec_latency
);

   localparam int unsigned OCC_W = ptr_width(PEND_DEPTH) + 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] now_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] completed_q, completed_d;
   logic [CNT_W-1:0] start_ts_q, start_ts_d;
   logic [CNT_W-1:0] wdog_q, wdog_d, wdog_inc;
   logic             start_q, start_d;
   logic             err_to_q, err_to_d;
   logic             err_pr_q, err_pr_d;
   logic             rec_valid_q, rec_valid_d;
   rec_t             rec_q, rec_d;

   logic             accept, push, pop, cont, timeout, launch;
   logic [CNT_W-1:0] fifo_head;
   logic             fifo_full, fifo_empty;
   logic [OCC_W-1:0] occ, occ_n;
   logic             idle_unused;

   assign idle_unused = k_ap_idle;

   ap_ctrl_ts_fifo #(
      .DEPTH (PEND_DEPTH),
      .W     (CNT_W)
   ) u_ts_fifo (
      .clk_i   (ap_clk),
      .rst_n_i (ap_rst_n),
      .flush_i (timeout),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (start_ts_q),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (occ)
   );

   assign accept   = start_q & k_ap_ready;
   assign push     = accept & (~fifo_full | pop);
   assign cont     = ~fifo_empty & (~rec_valid_q | rec_ready);
   assign pop      = k_ap_done & cont;
   assign wdog_inc = wdog_q + 1'b1;
   assign timeout  = ~fifo_empty & ~pop & (wdog_inc == CNT_W'(WDOG_CYC));

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      issued_d    = issued_q + CNT_W'(accept);
      completed_d = completed_q + CNT_W'(pop);
      case (state_q)
         IDLE, FIN: begin
            if (state_q == FIN) state_d = IDLE;
            if (run_start) begin
               if (run_count == '0) begin
                  state_d = FIN;
               end else begin
                  count_d     = run_count;
                  issued_d    = '0;
                  completed_d = '0;
                  state_d     = ISSUE;
               end
            end
         end
         ISSUE:   if (issued_q == count_q) state_d = DRAIN;
         DRAIN:   if (completed_q == count_q) state_d = FIN;
         default: state_d = IDLE;
      endcase
      if (timeout) state_d = FIN;

      // Raise start only if the slot it would fill is free after this cycle's push/pop.
      occ_n   = occ + OCC_W'(push) - OCC_W'(pop);
      start_d = (state_d == ISSUE) && (issued_d < count_d) && (occ_n < OCC_W'(PEND_DEPTH));
      if (start_q && !k_ap_ready) start_d = 1'b1;
      if (timeout) start_d = 1'b0;
      launch     = start_d & (~start_q | k_ap_ready);
      start_ts_d = launch ? now_q + 1'b1 : start_ts_q;

      wdog_d   = (~fifo_empty & ~pop & ~timeout) ? wdog_inc : '0;
      err_to_d = err_to_q | timeout;
      err_pr_d = err_pr_q | (k_ap_done & fifo_empty);

      rec_d       = rec_q;
      rec_valid_d = rec_valid_q;
      if (pop) begin
         rec_d.index   = completed_q;
         rec_d.latency = now_q - fifo_head + 1'b1;
         rec_valid_d   = 1'b1;
      end else if (rec_valid_q && rec_ready) begin
         rec_valid_d = 1'b0;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q     <= IDLE;
         now_q       <= '0;
         count_q     <= '0;
         issued_q    <= '0;
         completed_q <= '0;
         start_ts_q  <= '0;
         wdog_q      <= '0;
         start_q     <= 1'b0;
         err_to_q    <= 1'b0;
         err_pr_q    <= 1'b0;
         rec_valid_q <= 1'b0;
         rec_q       <= '0;
      end else begin
         state_q     <= state_d;
         now_q       <= now_q + 1'b1;
         count_q     <= count_d;
         issued_q    <= issued_d;
         completed_q <= completed_d;
         start_ts_q  <= start_ts_d;
         wdog_q      <= wdog_d;
         start_q     <= start_d;
         err_to_q    <= err_to_d;
         err_pr_q    <= err_pr_d;
         rec_valid_q <= rec_valid_d;
         rec_q       <= rec_d;
      end
   end

   assign busy          = (state_q == ISSUE) || (state_q == DRAIN);
   assign run_done      = (state_q == FIN);
   assign err_timeout   = err_to_q;
   assign err_protocol  = err_pr_q;
   assign k_ap_start    = start_q;
   assign k_ap_continue = cont;
   assign rec_valid     = rec_valid_q;
   assign rec_index     = rec_q.index;
   assign rec_latency   = rec_q.latency;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Bench for ap_ctrl_driver: behavioural kernel model, scoreboard of expected
// latency records and directed run scenarios.
module tb_ap_ctrl_driver;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic        run_start = 1'b0;
   logic [31:0] run_count = '0;
   logic        busy, run_done, err_timeout, err_protocol;
   logic        k_ap_start, k_ap_continue;
   logic        k_ap_ready = 1'b0;
   logic        k_ap_done = 1'b0;
   logic        k_ap_idle = 1'b1;
   logic        rec_valid;
   logic        rec_ready = 1'b1;
   logic [31:0] rec_index, rec_latency;

   always #5 ap_clk = ~ap_clk;

   ap_ctrl_driver #(
      .CNT_W      (32),
      .PEND_DEPTH (4),
      .WDOG_CYC   (100)
   ) dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .run_start     (run_start),
      .run_count     (run_count),
      .busy          (busy),
      .run_done      (run_done),
      .err_timeout   (err_timeout),
      .err_protocol  (err_protocol),
      .k_ap_start    (k_ap_start),
      .k_ap_ready    (k_ap_ready),
      .k_ap_done     (k_ap_done),
      .k_ap_idle     (k_ap_idle),
      .k_ap_continue (k_ap_continue),
      .rec_valid     (rec_valid),
      .rec_ready     (rec_ready),
      .rec_index     (rec_index),
      .rec_latency   (rec_latency)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Kernel model: accepts on start&ready, raises done m_lat cycles after accept,
   // holds done until continue.
   int cyc = 0;
   int acc_q[$];
   int m_lat = 10;
   bit m_rdy = 1'b1;
   bit m_done_en = 1'b1;
   bit m_spur = 1'b0;
   int outst_now = 0;
   bit phase_pipe = 1'b0;

   initial forever begin
      @(negedge ap_clk);
      cyc++;
      k_ap_ready = m_rdy;
      k_ap_done  = m_spur || (m_done_en && acc_q.size() > 0 && cyc >= acc_q[0] + m_lat);
      #1;
      outst_now = acc_q.size();
      if (ap_rst_n && k_ap_start && k_ap_ready) acc_q.push_back(cyc);
      if (ap_rst_n && k_ap_done && k_ap_continue && acc_q.size() > 0) void'(acc_q.pop_front());
   end

   typedef struct {
      int idx;
      int lat;
   } exp_t;
   exp_t exp_q[$];

   task automatic expect_rec(input int idx, input int lat);
      exp_t e;
      e.idx = idx;
      e.lat = lat;
      exp_q.push_back(e);
   endtask

   initial forever begin
      exp_t e;
      @(negedge ap_clk);
      #2;
      if (phase_pipe) begin
         chk("pipe_outstanding_le_4", outst_now <= 4, 1);
         if (outst_now == 4) chk("pipe_start_low_when_full", k_ap_start, 0);
      end
      if (rec_valid && rec_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_record: got index %0d latency %0d, expected none", rec_index, rec_latency);
         end else begin
            e = exp_q.pop_front();
            chk("rec_index", rec_index, e.idx);
            chk("rec_latency", rec_latency, e.lat);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge ap_clk);
   endtask

   task automatic pulse_run(input logic [31:0] n);
      run_count = n;
      run_start = 1'b1;
      @(negedge ap_clk);
      run_start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string name);
      int k;
      k = 0;
      #3;
      while (!run_done && k < bound) begin
         @(negedge ap_clk);
         #3;
         k++;
      end
      chk({name, "_run_done_seen"}, run_done, 1);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_run_done"}, run_done, 0);
      chk({name, "_err_timeout"}, err_timeout, 0);
      chk({name, "_err_protocol"}, err_protocol, 0);
      chk({name, "_k_ap_start"}, k_ap_start, 0);
      chk({name, "_k_ap_continue"}, k_ap_continue, 0);
      chk({name, "_rec_valid"}, rec_valid, 0);
      chk({name, "_rec_index"}, rec_index, 0);
      chk({name, "_rec_latency"}, rec_latency, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      tick(3);
      #3;
      chk_all_zero("reset");
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      tick(2);

      // zero-length run: run_done the next cycle, never busy
      pulse_run(0);
      #3;
      chk("zero_run_done", run_done, 1);
      chk("zero_busy", busy, 0);
      tick(1);
      #3;
      chk("zero_run_done_once", run_done, 0);

      // fixed-latency kernel, three invocations
      m_lat = 10;
      tick(1);
      for (int i = 0; i < 3; i++) expect_rec(i, 11);
      pulse_run(3);
      #3;
      chk("fixed_busy_in_run", busy, 1);
      wait_done(60, "fixed");
      chk("fixed_busy_falls_with_done", busy, 0);
      tick(1);
      #3;
      chk("fixed_run_done_once", run_done, 0);

      // pipelined kernel: FIFO fills at 4, then push/pop overlap
      m_lat = 20;
      tick(1);
      for (int i = 0; i < 8; i++) expect_rec(i, 21);
      phase_pipe = 1'b1;
      pulse_run(8);
      tick(10);
      #3;
      chk("pipe_full_start_low", k_ap_start, 0);
      chk("pipe_full_outstanding", outst_now, 4);
      wait_done(200, "pipe");
      phase_pipe = 1'b0;
      chk("pipe_all_records", exp_q.size(), 0);

      // record back-pressure while the kernel holds done
      rec_ready = 1'b0;
      m_lat = 5;
      tick(1);
      expect_rec(0, 6);
      expect_rec(1, 59);
      pulse_run(2);
      tick(9);
      for (int i = 0; i < 50; i++) begin
         #3;
         chk("bp_continue_low", k_ap_continue, 0);
         chk("bp_done_held", k_ap_done, 1);
         chk("bp_rec_valid", rec_valid, 1);
         chk("bp_rec_latency_stable", rec_latency, 6);
         chk("bp_rec_index_stable", rec_index, 0);
         @(negedge ap_clk);
      end
      rec_ready = 1'b1;
      wait_done(20, "bp");

      // watchdog: kernel never completes
      m_done_en = 1'b0;
      tick(1);
      pulse_run(2);
      tick(100);
      #3;
      chk("wdog_not_yet", err_timeout, 0);
      tick(1);
      #3;
      chk("wdog_err_timeout", err_timeout, 1);
      chk("wdog_run_done", run_done, 1);
      chk("wdog_busy", busy, 0);
      chk("wdog_start_dropped", k_ap_start, 0);
      acc_q.delete();
      m_done_en = 1'b1;
      tick(1);
      #3;
      chk("wdog_run_done_once", run_done, 0);
      chk("wdog_sticky", err_timeout, 1);
      chk("wdog_fifo_flushed", k_ap_continue, 0);

      // spurious done with nothing outstanding
      m_spur = 1'b1;
      tick(1);
      #3;
      chk("spur_continue_low", k_ap_continue, 0);
      m_spur = 1'b0;
      tick(1);
      #3;
      chk("spur_err_protocol", err_protocol, 1);
      chk("spur_no_record", rec_valid, 0);

      // reset in the middle of a run
      m_lat = 10;
      tick(1);
      pulse_run(5);
      tick(3);
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      acc_q.delete();
      #3;
      chk_all_zero("midrst");
      for (int i = 0; i < 20; i++) begin
         @(negedge ap_clk);
         #3;
         chk("midrst_no_run_done", run_done, 0);
         chk("midrst_no_start", k_ap_start, 0);
      end

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
